ras_ring: RTL and testbench

Parametrised return-address stack (RAS) for the frontend branch predictor. It is sized by the core configuration's RAS depth and XLEN, and stores predicted return addresses in a circular buffer. It improves on a plain shift-register RAS in four ways: it overwrites the oldest entry on overflow, merges a simultaneous push and pop into one update, supports any depth including non-power-of-two, and takes a one-deep checkpoint that is restored on branch misprediction.

---
 rtl/ras_ring.sv | 123 ++++++++++++
 tb/tb_ras_ring.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ras_ring.sv
// Circular-buffer return-address stack with overwrite-on-overflow, merged
// push+pop, arbitrary depth and a one-deep pointer/count checkpoint.
module ras_ring #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [XLEN-1:0]  data_i,
  input  logic             checkpoint_i,
  input  logic             restore_i,
  output logic [XLEN-1:0]  ra_o,
  output logic             ra_valid_o,
  output logic [CNT_W-1:0] count_o,
  output logic             overflow_o,
  output logic             underflow_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  logic [XLEN-1:0]  mem_reg [DEPTH];
  logic [PTR_W-1:0] ptr_reg, ptr_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [PTR_W-1:0] ck_ptr_reg;
  logic [CNT_W-1:0] ck_cnt_reg;
  logic             overflow_reg, overflow_next;
  logic             underflow_reg, underflow_next;

  logic [PTR_W-1:0] ptr_inc, top;
  logic             wr_en;
  logic [PTR_W-1:0] wr_idx;
  logic             empty;

  // Wrap by explicit compare so non-power-of-two depths stay in range.
  assign ptr_inc = (ptr_reg == PTR_MAX) ? '0 : ptr_reg + PTR_W'(1);
  assign top     = (ptr_reg == '0) ? PTR_MAX : ptr_reg - PTR_W'(1);
  assign empty   = (cnt_reg == '0);

  always_comb begin
    ptr_next       = ptr_reg;
    cnt_next       = cnt_reg;
    wr_en          = 1'b0;
    wr_idx         = ptr_reg;
    overflow_next  = 1'b0;
    underflow_next = 1'b0;
    if (flush_i) begin
      ptr_next = '0;
      cnt_next = '0;
    end else if (restore_i) begin
      ptr_next = ck_ptr_reg;
      cnt_next = ck_cnt_reg;
    end else if (push_i && pop_i && !empty) begin
      // Return then call: replace the top in place, depth unchanged.
      wr_en  = 1'b1;
      wr_idx = top;
    end else if (push_i) begin
      wr_en    = 1'b1;
      ptr_next = ptr_inc;
      if (cnt_reg == CNT_MAX) begin
        overflow_next = 1'b1;
      end else begin
        cnt_next = cnt_reg + CNT_W'(1);
      end
    end else if (pop_i) begin
      if (empty) begin
        underflow_next = 1'b1;
      end else begin
        ptr_next = top;
        cnt_next = cnt_reg - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_reg       <= '0;
      cnt_reg       <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      ptr_reg       <= ptr_next;
      cnt_reg       <= cnt_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  // Checkpoint captures pre-update state, independent of flush/restore.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ck_ptr_reg <= '0;
      ck_cnt_reg <= '0;
    end else if (checkpoint_i) begin
      ck_ptr_reg <= ptr_reg;
      ck_cnt_reg <= cnt_reg;
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          mem_reg[gi] <= '0;
        end else if (wr_en && (wr_idx == PTR_W'(gi))) begin
          mem_reg[gi] <= data_i;
        end
      end
    end
  endgenerate

  assign ra_o        = mem_reg[top];
  assign ra_valid_o  = !empty;
  assign count_o     = cnt_reg;
  assign overflow_o  = overflow_reg;
  assign underflow_o = underflow_reg;

endmodule

// File: tb/tb_ras_ring.sv
// Directed bench for ras_ring at depths 2, 4 and 3; expectations are queued
// with each stimulus step and checked one cycle later.
module tb_ras_ring;

  logic clk;
  logic rst_n;
  logic        flush [3];
  logic        push  [3];
  logic        pop   [3];
  logic        ck    [3];
  logic        rs    [3];
  logic [31:0] data  [3];

  logic [31:0] ra0, ra1, ra2;
  logic        v0, v1, v2;
  logic [1:0]  c0;
  logic [2:0]  c1;
  logic [1:0]  c2;
  logic        ov0, ov1, ov2, un0, un1, un2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    int          inst;
    logic [31:0] ra;
    bit          chk_ra;
    logic        valid;
    int          cnt;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t sb[$];

  ras_ring #(.XLEN(32), .DEPTH(2)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush[0]), .push_i(push[0]),
    .pop_i(pop[0]), .data_i(data[0]), .checkpoint_i(ck[0]), .restore_i(rs[0]),
    .ra_o(ra0), .ra_valid_o(v0), .count_o(c0), .overflow_o(ov0), .underflow_o(un0)
  );

  ras_ring #(.XLEN(32), .DEPTH(4)) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush[1]), .push_i(push[1]),
    .pop_i(pop[1]), .data_i(data[1]), .checkpoint_i(ck[1]), .restore_i(rs[1]),
    .ra_o(ra1), .ra_valid_o(v1), .count_o(c1), .overflow_o(ov1), .underflow_o(un1)
  );

  ras_ring #(.XLEN(32), .DEPTH(3)) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush[2]), .push_i(push[2]),
    .pop_i(pop[2]), .data_i(data[2]), .checkpoint_i(ck[2]), .restore_i(rs[2]),
    .ra_o(ra2), .ra_valid_o(v2), .count_o(c2), .overflow_o(ov2), .underflow_o(un2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input string what, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s observed=0x%0h expected=0x%0h", tag, what, obs, exp);
    end
  endtask

  task automatic get_out(input int inst, output logic [31:0] ra, output logic v,
                         output logic [31:0] cnt, output logic ov, output logic un);
    case (inst)
      0: begin ra = ra0; v = v0; cnt = 32'(c0); ov = ov0; un = un0; end
      1: begin ra = ra1; v = v1; cnt = 32'(c1); ov = ov1; un = un1; end
      default: begin ra = ra2; v = v2; cnt = 32'(c2); ov = ov2; un = un2; end
    endcase
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < 3; i++) begin
      flush[i] = 1'b0; push[i] = 1'b0; pop[i] = 1'b0;
      ck[i] = 1'b0; rs[i] = 1'b0; data[i] = 32'h0;
    end
  endtask

  // One cycle of stimulus on one instance, then compare after the edge.
  task automatic op(input int inst, input string tag,
                    input logic f, input logic pu, input logic po, input logic [31:0] d,
                    input logic c, input logic r,
                    input logic [31:0] era, input bit cra, input logic ev,
                    input int ecnt, input logic eov, input logic eun);
    exp_t e;
    logic [31:0] ra, cnt;
    logic v, ov, un;
    clear_inputs();
    flush[inst] = f; push[inst] = pu; pop[inst] = po;
    data[inst] = d; ck[inst] = c; rs[inst] = r;
    sb.push_back('{tag, inst, era, cra, ev, ecnt, eov, eun});
    @(posedge clk);
    #1;
    clear_inputs();
    e = sb.pop_front();
    get_out(e.inst, ra, v, cnt, ov, un);
    if (e.chk_ra) chk(e.tag, "ra", ra, e.ra);
    chk(e.tag, "valid", 32'(v), 32'(e.valid));
    chk(e.tag, "count", cnt, 32'(e.cnt));
    chk(e.tag, "overflow", 32'(ov), 32'(e.ovf));
    chk(e.tag, "underflow", 32'(un), 32'(e.unf));
    $display("step %-14s inst=%0d ra=0x%0h valid=%0b count=%0d ovf=%0b unf=%0b",
             tag, inst, ra, v, cnt, ov, un);
  endtask

  task automatic check_reset_state(input string tag);
    logic [31:0] ra, cnt;
    logic v, ov, un;
    for (int i = 0; i < 3; i++) begin
      get_out(i, ra, v, cnt, ov, un);
      chk(tag, "ra", ra, 32'h0);
      chk(tag, "valid", 32'(v), 32'h0);
      chk(tag, "count", cnt, 32'h0);
      chk(tag, "overflow", 32'(ov), 32'h0);
      chk(tag, "underflow", 32'(un), 32'h0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    rst_n = 1'b1;

    //     inst tag            f  pu po data   ck rs   ra     cra v  cnt ov un
    // DEPTH=2: basic push, overflow/underflow
    op(0, "idle0",         0, 0, 0, 32'h0,   0, 0,  32'h0,   1, 0, 0, 0, 0);
    op(0, "push100",       0, 1, 0, 32'h100, 0, 0,  32'h100, 1, 1, 1, 0, 0);
    op(0, "flush",         1, 0, 0, 32'h0,   0, 0,  32'h0,   0, 0, 0, 0, 0);
    op(0, "pushA",         0, 1, 0, 32'hA,   0, 0,  32'hA,   1, 1, 1, 0, 0);
    op(0, "pushB",         0, 1, 0, 32'hB,   0, 0,  32'hB,   1, 1, 2, 0, 0);
    op(0, "pushC_ovf",     0, 1, 0, 32'hC,   0, 0,  32'hC,   1, 1, 2, 1, 0);
    op(0, "idle_ovf_end",  0, 0, 0, 32'h0,   0, 0,  32'hC,   1, 1, 2, 0, 0);
    op(0, "pop1",          0, 0, 1, 32'h0,   0, 0,  32'hB,   1, 1, 1, 0, 0);
    op(0, "pop2",          0, 0, 1, 32'h0,   0, 0,  32'h0,   0, 0, 0, 0, 0);
    op(0, "pop_unf",       0, 0, 1, 32'h0,   0, 0,  32'h0,   0, 0, 0, 0, 1);
    op(0, "idle_unf_end",  0, 0, 0, 32'h0,   0, 0,  32'h0,   0, 0, 0, 0, 0);
    // simultaneous push+pop
    op(0, "pushA2",        0, 1, 0, 32'hA,   0, 0,  32'hA,   1, 1, 1, 0, 0);
    op(0, "pushpopD",      0, 1, 1, 32'hD,   0, 0,  32'hD,   1, 1, 1, 0, 0);
    op(0, "popD",          0, 0, 1, 32'h0,   0, 0,  32'h0,   0, 0, 0, 0, 0);
    op(0, "pushpopE_emp",  0, 1, 1, 32'hE,   0, 0,  32'hE,   1, 1, 1, 0, 0);
    // flush priority
    op(0, "push2",         0, 1, 0, 32'h2,   0, 0,  32'h2,   1, 1, 2, 0, 0);
    op(0, "flush_push",    1, 1, 0, 32'hF,   0, 0,  32'h0,   0, 0, 0, 0, 0);
    op(0, "push1",         0, 1, 0, 32'h1,   0, 0,  32'h1,   1, 1, 1, 0, 0);
    op(0, "ckpt",          0, 0, 0, 32'h0,   1, 0,  32'h1,   1, 1, 1, 0, 0);
    op(0, "push5",         0, 1, 0, 32'h5,   0, 0,  32'h5,   1, 1, 2, 0, 0);
    op(0, "flush_restore", 1, 0, 0, 32'h0,   0, 1,  32'h0,   0, 0, 0, 0, 0);
    op(0, "restore_late",  0, 0, 0, 32'h0,   0, 1,  32'h1,   1, 1, 1, 0, 0);

    // DEPTH=4: checkpoint and restore
    op(1, "d4_pushA",      0, 1, 0, 32'hA,   0, 0,  32'hA,   1, 1, 1, 0, 0);
    op(1, "d4_ckpt",       0, 0, 0, 32'h0,   1, 0,  32'hA,   1, 1, 1, 0, 0);
    op(1, "d4_pushB",      0, 1, 0, 32'hB,   0, 0,  32'hB,   1, 1, 2, 0, 0);
    op(1, "d4_pushC",      0, 1, 0, 32'hC,   0, 0,  32'hC,   1, 1, 3, 0, 0);
    op(1, "d4_restore_pu", 0, 1, 0, 32'h99,  0, 1,  32'hA,   1, 1, 1, 0, 0);
    op(1, "d4_pop",        0, 0, 1, 32'h0,   0, 0,  32'h0,   0, 0, 0, 0, 0);
    op(1, "d4_push7_ck",   0, 1, 0, 32'h7,   1, 0,  32'h7,   1, 1, 1, 0, 0);
    op(1, "d4_push8",      0, 1, 0, 32'h8,   0, 0,  32'h8,   1, 1, 2, 0, 0);
    op(1, "d4_restore0",   0, 0, 0, 32'h0,   0, 1,  32'h0,   0, 0, 0, 0, 0);

    // DEPTH=3: non-power-of-two wrap
    op(2, "d3_push1",      0, 1, 0, 32'h1,   0, 0,  32'h1,   1, 1, 1, 0, 0);
    op(2, "d3_push2",      0, 1, 0, 32'h2,   0, 0,  32'h2,   1, 1, 2, 0, 0);
    op(2, "d3_push3",      0, 1, 0, 32'h3,   0, 0,  32'h3,   1, 1, 3, 0, 0);
    op(2, "d3_push4_ovf",  0, 1, 0, 32'h4,   0, 0,  32'h4,   1, 1, 3, 1, 0);
    op(2, "d3_pop_to3",    0, 0, 1, 32'h0,   0, 0,  32'h3,   1, 1, 2, 0, 0);
    op(2, "d3_pop_to2",    0, 0, 1, 32'h0,   0, 0,  32'h2,   1, 1, 1, 0, 0);
    op(2, "d3_pop_empty",  0, 0, 1, 32'h0,   0, 0,  32'h0,   0, 0, 0, 0, 0);
    op(2, "d3_pop_unf",    0, 0, 1, 32'h0,   0, 0,  32'h0,   0, 0, 0, 0, 1);
    op(2, "d3_push9",      0, 1, 0, 32'h9,   0, 0,  32'h9,   1, 1, 1, 0, 0);

    // Asynchronous reset mid-sequence clears state without a clock edge.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_state("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    op(0, "post_reset",    0, 0, 0, 32'h0,   0, 0,  32'h0,   1, 0, 0, 0, 0);

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
